// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, parametrised ALU. Single-cycle ops take one clock; MUL
// (op 1011) runs an iterative shift-add over WIDTH clocks. The result and the
// Z/C/N/V flags are held registered until the consumer accepts them.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   in_valid/in_ready   input handshake; a, b, op captured on transfer
//   a, b [WIDTH]        operands
//   op [4]              opcode
//   out_valid/out_ready output handshake
//   result [WIDTH]      registered result
//   zf, cf, nf, vf      zero, carry/borrow/shift-out, negative, signed overflow
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             cf,
    output logic             nf,
    output logic             vf
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_MUL = 4'b1011;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zf_q, zf_d, cf_q, cf_d, nf_q, nf_d, vf_q, vf_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept;
    logic [WIDTH-1:0]   one_w;
    logic [WIDTH:0]     add_ext, inc_ext;
    logic [WIDTH-1:0]   sub_res, dec_res;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cf, alu_vf;
    logic [2*WIDTH-1:0] acc_step;

    assign one_w     = {{(WIDTH-1){1'b0}}, 1'b1};
    // Gated by rst_n so nothing appears ready while reset is held.
    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;

    assign add_ext  = {1'b0, a} + {1'b0, b};
    assign inc_ext  = {1'b0, a} + {1'b0, one_w};
    assign sub_res  = a - b;
    assign dec_res  = a - one_w;
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle datapath, evaluated on the live inputs at acceptance.
    always_comb begin
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_vf  = 1'b0;
        unique case (op)
            4'b0000: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_cf  = add_ext[WIDTH];
                alu_vf  = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
            end
            4'b0001: begin
                alu_res = sub_res;
                alu_cf  = (a < b);
                alu_vf  = (a[MSB] != b[MSB]) && (sub_res[MSB] != a[MSB]);
            end
            4'b0010: alu_res = a & b;
            4'b0011: alu_res = a | b;
            4'b0100: alu_res = a ^ b;
            4'b0101: alu_res = ~a;
            4'b0110: begin
                alu_res = inc_ext[WIDTH-1:0];
                alu_cf  = inc_ext[WIDTH];
                alu_vf  = !a[MSB] && inc_ext[MSB];
            end
            4'b0111: begin
                alu_res = dec_res;
                alu_cf  = (a == '0);
                alu_vf  = a[MSB] && !dec_res[MSB];
            end
            4'b1000: begin
                alu_res = {a[WIDTH-2:0], 1'b0};
                alu_cf  = a[MSB];
            end
            4'b1001: begin
                alu_res = {1'b0, a[WIDTH-1:1]};
                alu_cf  = a[0];
            end
            4'b1010: alu_res = (a == b) ? '0 : one_w;
            4'b1100: alu_res = ($signed(a) < $signed(b)) ? one_w : '0;
            default: alu_res = '0; // MUL handled iteratively; 1101..1111 yield 0
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        nf_d     = nf_q;
        vf_d     = vf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;

        if (state_q == BUSY) begin
            acc_d    = acc_step;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d  = DONE;
                result_d = acc_step[WIDTH-1:0];
                zf_d     = (acc_step[WIDTH-1:0] == '0);
                nf_d     = acc_step[MSB];
                cf_d     = |acc_step[2*WIDTH-1:WIDTH];
                vf_d     = 1'b0;
            end
        end else if (state_q == DONE && out_ready && !in_valid) begin
            state_d = IDLE;
        end else if (state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
        end

        if (accept) begin
            if (op == OP_MUL) begin
                state_d  = BUSY;
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                state_d  = DONE;
                result_d = alu_res;
                zf_d     = (alu_res == '0);
                nf_d     = alu_res[MSB];
                cf_d     = alu_cf;
                vf_d     = alu_vf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            nf_q     <= 1'b0;
            vf_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            nf_q     <= nf_d;
            vf_q     <= vf_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = result_q;
    assign zf     = zf_q;
    assign cf     = cf_q;
    assign nf     = nf_q;
    assign vf     = vf_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, result;
    logic [3:0] op;
    logic       zf, cf, nf, vf;

    int checks   = 0;
    int failures = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zf        (zf),
        .cf        (cf),
        .nf        (nf),
        .vf        (vf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input logic [7:0] r,
                         input logic z, input logic c, input logic n, input logic v);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".result"}, {24'd0, result}, {24'd0, r});
        chk({tag, ".flags"}, {28'd0, zf, cf, nf, vf}, {28'd0, z, c, n, v});
    endtask

    initial begin
        // Reset with in_valid held high.
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        op = 4'b0000; a = 8'hFF; b = 8'h01;
        step(); step();
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.result", {24'd0, result}, 32'd0);
        chk("rst.flags", {28'd0, zf, cf, nf, vf}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel.out_valid", {31'd0, out_valid}, 32'd0);

        // FF + 01 wraps to zero with carry.
        step();
        flags("add_wrap", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

        // 7F + 01: signed overflow.
        a = 8'h7F; b = 8'h01;
        step();
        flags("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);

        // 00 - 01: borrow, no overflow.
        op = 4'b0001; a = 8'h00; b = 8'h01;
        step();
        flags("sub_borrow", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);

        in_valid = 1'b0;
        step();
        chk("idle.out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle.in_ready", {31'd0, in_ready}, 32'd1);

        // MUL 0x10 * 0x11 = 0x110; operands changed after acceptance must be ignored.
        in_valid = 1'b1; op = 4'b1011; a = 8'h10; b = 8'h11;
        step();
        in_valid = 1'b0; a = 8'h33; b = 8'h77; op = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mul.busy_ready%0d", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("mul.busy_valid%0d", i), {31'd0, out_valid}, 32'd0);
            step();
        end
        flags("mul", 8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        chk("mul.drain", {31'd0, out_valid}, 32'd0);

        // MUL aborted by reset in its 4th busy cycle.
        in_valid = 1'b1; op = 4'b1011; a = 8'h03; b = 8'h05;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("abort.in_rst_valid", {31'd0, out_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("abort.valid%0d", i), {31'd0, out_valid}, 32'd0);
            step();
        end
        chk("abort.idle_ready", {31'd0, in_ready}, 32'd1);

        // Backpressure: A5 ^ 0F = AA held while out_ready=0.
        out_ready = 1'b0; in_valid = 1'b1; op = 4'b0100; a = 8'hA5; b = 8'h0F;
        step();
        op = 4'b0000; a = 8'h01; b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            flags($sformatf("bp%0d", i), 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("bp.in_ready%0d", i), {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", {31'd0, in_ready}, 32'd1);
        step();
        flags("b2b_add", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

        // Signed compare: -2 < 1.
        op = 4'b1100; a = 8'hFE; b = 8'h01;
        step();
        flags("slt", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

        op = 4'b1010; a = 8'h5A; b = 8'h5A;
        step();
        flags("eq", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        op = 4'b1111; a = 8'h03; b = 8'h04;
        step();
        flags("rsvd", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        op = 4'b1001; a = 8'h81;
        step();
        flags("shr", 8'h40, 1'b0, 1'b1, 1'b0, 1'b0);

        op = 4'b0110; a = 8'h7F;
        step();
        flags("inc_ovf", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);

        op = 4'b0111; a = 8'h00;
        step();
        flags("dec_borrow", 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);

        in_valid = 1'b0;
        step();
        chk("end.out_valid", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
